// File: rtl/seq_pkg.sv
// Shared types and default sizing for the serial sequence-detection datapath.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_FRAME_LEN = 8;
  localparam int DEF_PAT_W     = 4;
  localparam int DEF_CNT_W     = $clog2(DEF_FRAME_LEN + 1);

endpackage

// File: rtl/seq_window_cmp.sv
// Sliding bit window with a combinational compare of the next window against the pattern.
module seq_window_cmp
  #(parameter int PAT_W = 4)
  (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_shift_en,
    input  logic             i_bit,
    input  logic             i_full,
    input  logic [PAT_W-1:0] i_pattern,
    output logic             o_hit
  );

  // Only the newest PAT_W-1 bits are stored: the oldest bit shifts out before it is ever compared.
  logic [PAT_W-2:0] r_window;
  logic [PAT_W-1:0] w_window_next;

  assign w_window_next = {r_window, i_bit};

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_window <= '0;
    end else if (i_shift_en) begin
      r_window <= w_window_next[PAT_W-2:0];
    end
  end

  assign o_hit = i_shift_en & i_full & (w_window_next == i_pattern);

endmodule

// File: rtl/seq_frame_ctrl.sv
// Frame controller: sequences FRAME_LEN qualified bits, records per-slot pattern hits,
// and presents the hit vector and count on a valid/ready result port.
module seq_frame_ctrl
  import seq_pkg::*;
  #(
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int PAT_W     = DEF_PAT_W
  )
  (
    input  logic                           clk,
    input  logic                           Reset,
    input  logic                           cfg_we,
    input  logic [PAT_W-1:0]               cfg_pat,
    input  logic                           cont,
    input  logic                           start,
    input  logic                           bit_valid,
    input  logic                           P1,
    output logic                           busy,
    output logic                           match,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [FRAME_LEN-1:0]           res_hits,
    output logic [$clog2(FRAME_LEN+1)-1:0] res_count,
    output logic                           err_drop
  );

  localparam int CNT_W  = $clog2(FRAME_LEN + 1);
  localparam int SLOT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_LEN - 1);
  localparam logic [SLOT_W-1:0] FULL_SLOT = SLOT_W'(PAT_W - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [PAT_W-1:0]     r_pattern;
  logic [SLOT_W-1:0]    r_slot;
  logic [FRAME_LEN-1:0] r_acc;
  logic [FRAME_LEN-1:0] w_acc_next;
  logic [FRAME_LEN-1:0] r_hits;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     w_count_next;
  logic                 r_match;
  logic                 r_err_drop;
  logic                 w_arm;
  logic                 w_shift;
  logic                 w_last;
  logic                 w_drop;
  logic                 w_full;
  logic                 w_hit;

  // Handshake is res_valid & res_ready; in DONE the result registers hold until it happens.
  always_comb begin
    w_state_next = r_state;
    w_arm        = 1'b0;
    w_shift      = 1'b0;
    w_last       = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_RUN;
          w_arm        = 1'b1;
        end
      end
      ST_RUN: begin
        if (bit_valid) begin
          w_shift = 1'b1;
          if (r_slot == LAST_SLOT) begin
            w_last       = 1'b1;
            w_state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_drop = bit_valid;
        if (res_ready) begin
          if (cont) begin
            w_state_next = ST_RUN;
            w_arm        = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign w_full = (r_slot >= FULL_SLOT);

  seq_window_cmp #(.PAT_W(PAT_W)) u_window (
    .i_clk      (clk),
    .i_rst      (Reset),
    .i_clr      (w_arm),
    .i_shift_en (w_shift),
    .i_bit      (P1),
    .i_full     (w_full),
    .i_pattern  (r_pattern),
    .o_hit      (w_hit)
  );

  assign w_acc_next = r_acc | (FRAME_LEN'(w_hit) << r_slot);

  always_comb begin
    w_count_next = '0;
    for (int k = 0; k < FRAME_LEN; k++) begin
      w_count_next = w_count_next + CNT_W'(w_acc_next[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_pattern  <= '0;
      r_slot     <= '0;
      r_acc      <= '0;
      r_hits     <= '0;
      r_count    <= '0;
      r_match    <= 1'b0;
      r_err_drop <= 1'b0;
    end else begin
      r_match <= w_hit;
      if (r_state == ST_IDLE && cfg_we) begin
        r_pattern <= cfg_pat;
      end
      // Arming a fresh frame wins over a dropped bit in the same handshake cycle.
      if (w_arm) begin
        r_slot     <= '0;
        r_acc      <= '0;
        r_err_drop <= 1'b0;
      end else begin
        if (w_shift) begin
          r_slot <= r_slot + SLOT_W'(1);
          r_acc  <= w_acc_next;
        end
        if (w_drop) begin
          r_err_drop <= 1'b1;
        end
      end
      if (w_last) begin
        r_hits  <= w_acc_next;
        r_count <= w_count_next;
      end
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign res_valid = (r_state == ST_DONE);
  assign match     = r_match;
  assign res_hits  = r_hits;
  assign res_count = r_count;
  assign err_drop  = r_err_drop;

endmodule

// File: doc/seq_frame_ctrl.md
# seq_frame_ctrl

Frame controller for the serial sequence-detection datapath. It holds the programmed pattern and sequences fixed-length frames of qualified serial bits. It tracks the sliding pattern window and records one hit flag per bit slot. At frame end it presents the hit vector and hit count on a valid/ready result port, in single-shot or continuous mode.

## Interface
Parameters:
- FRAME_LEN, 8, bit slots per frame (≥ PAT_W)
- PAT_W, 4, pattern/window width (≥ 2)

Ports (clock and reset first):
- clk  in  1  sole clock, all logic on posedge
- Reset  in  1  synchronous, active-high reset
- cfg_we  in  1  load cfg_pat into pattern register (honoured only in IDLE)
- cfg_pat  in  PAT_W  pattern to detect
- cont  in  1  continuous mode: re-arm automatically after each result handshake
- start  in  1  begin a frame (honoured only in IDLE)
- bit_valid  in  1  P1 carries a qualified serial bit this cycle
- P1  in  1  serial data bit
- busy  out  1  state ≠ IDLE
- match  out  1  registered one-cycle pulse, cycle after a hitting bit
- res_valid  out  1  result available (DONE state)
- res_ready  in  1  consumer accepts result
- res_hits  out  FRAME_LEN  bit k = hit at slot k (slot 0 = first bit of frame)
- res_count  out  $clog2(FRAME_LEN+1)  popcount of res_hits
- err_drop  out  1  sticky: bit_valid arrived while in DONE

## Operation
- States: IDLE → RUN → DONE → (IDLE | RUN).
- IDLE: cfg_we loads the pattern. start → RUN. On entry to RUN: window, slot counter and hit accumulator are cleared, and err_drop is cleared.
- cfg_we and start in the same IDLE cycle: the new pattern applies to that frame.
- RUN, per bit_valid:
  - window_next = {window[PAT_W-2:0], P1}.
  - Hit when slot ≥ PAT_W-1 and window_next == pattern. Partial windows never hit.
  - Hit sets acc[slot] and pulses match the next cycle.
  - slot increments. The bit at slot FRAME_LEN-1 transitions to DONE, with the final hit included.
- DONE:
  - res_valid=1; res_hits and res_count are stable until handshake.
  - bit_valid is ignored and sets err_drop.
  - start and cfg_we are ignored.
- Handshake: res_valid & res_ready.
  - cont=0 → IDLE.
  - cont=1 → RUN with a fresh frame; a bit_valid in that same handshake cycle is discarded.
- res_count is computed from the accumulator and registered on the DONE transition.
- Pattern register persists across frames; only Reset or cfg_we in IDLE changes it.

## Timing
- Reset (synchronous, 1 cycle) forces:
  - state IDLE
  - pattern, window, slot = 0
  - busy, match, res_valid, err_drop = 0
  - res_hits, res_count = 0
- Reset mid-frame or in DONE aborts without producing a result.
- start in cycle t → busy=1 at t+1; the first bit counted is from cycle t+1.
- Last bit in cycle t → res_valid=1, res_hits/res_count valid at t+1.
- Minimum frame = FRAME_LEN+1 cycles from start to res_valid.
- Handshake in cycle t → res_valid=0 at t+1.
  - cont=1: busy stays 1 and the first bit of the next frame can be accepted at t+1.
- Gaps in bit_valid stall the frame indefinitely; no timeout.
- match is never asserted outside the cycle after a RUN hit.

## Structure
- Shared package seq_pkg:
  - state enum (IDLE, RUN, DONE)
  - default FRAME_LEN / PAT_W constants
  - localparam for count width
- Sub-module seq_window_cmp:
  - PAT_W shift window with clear/shift-enable.
  - Combinational equality of window_next against the pattern.
  - Qualified by a "window full" input from the slot counter.
- Top level holds the FSM, slot counter, accumulator, popcount and result registers.

## Test plan
- Pattern 1011, cont=0, bits 1,0,1,1,0,1,1,0 back-to-back → res_hits=8'b0100_1000, res_count=2, match pulses after slots 3 and 6.
- Pattern 0000, all-zero frame → res_hits=8'b1111_1000, res_count=5 (slots 0–2 excluded).
- Backpressure:
  - Stimulus: res_ready low 5 cycles after DONE, 2 bit_valid pulses during that time.
  - Required: err_drop=1, res_hits unchanged; on handshake → IDLE.
  - Next start clears err_drop.
- Continuous mode:
  - Stimulus: cont=1, two frames back-to-back.
  - Required: handshake cycle with bit_valid discards that bit; second frame result is independent of the first; busy never drops.
- Reset asserted after 3 bits of a frame → all outputs 0, IDLE, pattern 0; next frame with pattern 0000 and zeros gives res_count=5.
- cfg_we=1 with cfg_pat=1111 during RUN → ignored; frame still matches the old pattern. Same in IDLE together with start → new pattern used.
